// File: rtl/axi_portal_pkg.sv
// Shared types and constants for the portal AXI master.
package axi_portal_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWaddr,
        StWdata,
        StWresp,
        StTout
    } axi_master_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY    = 2'd0;
    localparam logic [1:0]  AXI_RESP_SLVERR  = 2'd2;
    localparam logic [31:0] AXI_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_watchdog.sv
// Stall counter: counts enabled cycles without a transfer and flags expiry at LIMIT.
module axi_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic CLK,
    input  logic nRST,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;

    assign expire_o = en_i && (cnt_q == 16'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_portal_master.sv
// Request-pipe to AXI3 master bridge, one transaction outstanding.
// Optional watchdog and idle drain enabled by AXI_MASTER_TIMEOUT_EN.
module axi_portal_master
    import axi_portal_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [3:0]            req_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  rsp_write_o,
    output logic                  rsp_err_o,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output logic [ID_WIDTH-1:0]   ar_id_o,
    output logic [3:0]            ar_len_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic [ID_WIDTH-1:0]   aw_id_o,
    output logic [3:0]            aw_len_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [ID_WIDTH-1:0]   w_id_o,
    output logic                  w_last_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic [ID_WIDTH-1:0]   r_id_i,
    input  logic                  r_last_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [ID_WIDTH-1:0]   b_id_i,
    input  logic [1:0]            b_resp_i
);

    axi_master_state_t     state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    // Holds req_ready low for the first cycle after reset release.
    logic                  init_q;

    logic last_beat, hs_r, hs_w, hs_b, tout_expire, drain;

    assign last_beat = (beat_q == len_q);
    assign hs_r = (state_q == StRdata) && r_valid_i && rsp_ready_i;
    assign hs_w = (state_q == StWdata) && wdata_valid_i && w_ready_i;
    assign hs_b = (state_q == StWresp) && b_valid_i && rsp_ready_i;

`ifdef AXI_MASTER_TIMEOUT_EN
    axi_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .en_i    ((state_q == StRdata) || (state_q == StWdata) || (state_q == StWresp)),
        .clr_i   (hs_r || hs_w || hs_b),
        .expire_o(tout_expire)
    );
    assign drain = 1'b1;
`else
    assign tout_expire = 1'b0;
    assign drain       = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        tid_d         = tid_q;
        req_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_data_o    = '0;
        rsp_last_o    = 1'b0;
        rsp_write_o   = 1'b0;
        rsp_err_o     = 1'b0;
        ar_valid_o    = 1'b0;
        aw_valid_o    = 1'b0;
        w_valid_o     = 1'b0;
        w_data_o      = '0;
        w_last_o      = 1'b0;
        r_ready_o     = 1'b0;
        b_ready_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready_o = init_q;
                r_ready_o   = drain && init_q;
                b_ready_o   = drain && init_q;
                if (req_valid_i && init_q) begin
                    addr_d  = req_addr_i;
                    len_d   = req_len_i;
                    tid_d   = tid_q + ID_WIDTH'(1);
                    state_d = req_write_i ? StWaddr : StRaddr;
                end
            end
            StRaddr: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    beat_d  = '0;
                    state_d = StRdata;
                end
            end
            StRdata: begin
                r_ready_o   = rsp_ready_i;
                rsp_valid_o = r_valid_i;
                rsp_data_o  = r_data_i;
                rsp_last_o  = last_beat;
                rsp_err_o   = (r_resp_i != AXI_RESP_OKAY) || (r_id_i != tid_q)
                              || (r_last_i != last_beat);
                if (hs_r) begin
                    beat_d = beat_q + 4'd1;
                    if (last_beat) state_d = StIdle;
                end else if (tout_expire) begin
                    state_d = StTout;
                end
            end
            StWaddr: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    beat_d  = '0;
                    state_d = StWdata;
                end
            end
            StWdata: begin
                w_valid_o     = wdata_valid_i;
                wdata_ready_o = w_ready_i;
                w_data_o      = wdata_i;
                w_last_o      = last_beat;
                if (hs_w) begin
                    beat_d = beat_q + 4'd1;
                    if (last_beat) state_d = StWresp;
                end else if (tout_expire) begin
                    state_d = StTout;
                end
            end
            StWresp: begin
                b_ready_o   = rsp_ready_i;
                rsp_valid_o = b_valid_i;
                rsp_write_o = 1'b1;
                rsp_last_o  = 1'b1;
                rsp_err_o   = (b_resp_i != AXI_RESP_OKAY) || (b_id_i != tid_q);
                if (hs_b) begin
                    state_d = StIdle;
                end else if (tout_expire) begin
                    state_d = StTout;
                end
            end
            StTout: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = DATA_WIDTH'(AXI_TIMEOUT_DATA);
                rsp_last_o  = 1'b1;
                rsp_err_o   = 1'b1;
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Address channels are driven straight from the latched request registers.
    assign ar_addr_o = addr_q;
    assign ar_len_o  = len_q;
    assign ar_id_o   = tid_q;
    assign aw_addr_o = addr_q;
    assign aw_len_o  = len_q;
    assign aw_id_o   = tid_q;
    assign w_id_o    = tid_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tid_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tid_q   <= tid_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_portal_master.sv
// Directed bench for axi_portal_master; ID_WIDTH=2 so the id wrap is reached quickly.
module tb_axi_portal_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_len = '0;
    logic          wdata_valid = 1'b0, wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_write, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          ar_valid, ar_ready = 1'b0, aw_valid, aw_ready = 1'b0;
    logic [AW-1:0] ar_addr, aw_addr;
    logic [IW-1:0] ar_id, aw_id, w_id;
    logic [3:0]    ar_len, aw_len;
    logic          w_valid, w_ready = 1'b0, w_last;
    logic [DW-1:0] w_data;
    logic          r_valid = 1'b0, r_ready, r_last = 1'b0;
    logic [DW-1:0] r_data = '0;
    logic [IW-1:0] r_id = '0, b_id = '0;
    logic [1:0]    r_resp = '0, b_resp = '0;
    logic          b_valid = 1'b0, b_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_portal_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW)
    ) dut (
        .CLK(clk), .nRST(nrst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_last_o(rsp_last), .rsp_write_o(rsp_write), .rsp_err_o(rsp_err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_id_o(ar_id), .ar_len_o(ar_len),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
        .aw_id_o(aw_id), .aw_len_o(aw_len),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
        .w_id_o(w_id), .w_last_o(w_last),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
        .r_id_i(r_id), .r_last_i(r_last), .r_resp_i(r_resp),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id), .b_resp_i(b_resp)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          bad_id;
        logic          bad_last;
        int            stall;
        logic [DW-1:0] data0;
        logic          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_len = v.len;
        #1 chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid   = 1'b0;
        wdata_valid = v.write;
        wdata       = 32'hFFFF_FFFF;
        #1;
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (v.write) begin
            chk("aw_valid", 64'(aw_valid), 64'd1);
            chk("aw_addr", 64'(aw_addr), 64'(v.addr));
            chk("aw_len", 64'(aw_len), 64'(v.len));
            chk("aw_id", 64'(aw_id), 64'(v.id));
            chk("w_before_aw", 64'(w_valid), 64'd0);
            chk("wready_before_aw", 64'(wdata_ready), 64'd0);
        end else begin
            chk("ar_valid", 64'(ar_valid), 64'd1);
            chk("ar_addr", 64'(ar_addr), 64'(v.addr));
            chk("ar_len", 64'(ar_len), 64'(v.len));
            chk("ar_id", 64'(ar_id), 64'(v.id));
        end
        @(negedge clk);
        aw_ready = v.write;
        ar_ready = !v.write;
        #1 chk("addr_valid_held", 64'(v.write ? aw_valid : ar_valid), 64'd1);
        @(negedge clk);
        aw_ready = 1'b0; ar_ready = 1'b0; wdata_valid = 1'b0;
        if (!v.write) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                r_valid = 1'b1;
                r_data  = v.data0 + 32'(i);
                r_id    = v.bad_id ? ~v.id : v.id;
                r_last  = (i == int'(v.len)) ^ v.bad_last;
                r_resp  = v.resp;
                if (i == 1) begin
                    for (int s = 0; s < v.stall; s++) begin
                        rsp_ready = 1'b0;
                        #1;
                        chk("stall_r_ready", 64'(r_ready), 64'd0);
                        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
                        @(negedge clk);
                    end
                end
                rsp_ready = 1'b1;
                #1;
                chk("rsp_valid", 64'(rsp_valid), 64'd1);
                chk("r_ready", 64'(r_ready), 64'd1);
                chk("rsp_data", 64'(rsp_data), 64'(v.data0 + 32'(i)));
                chk("rsp_last", 64'(i == int'(v.len)), 64'(rsp_last));
                chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
                chk("rsp_write_rd", 64'(rsp_write), 64'd0);
                @(negedge clk);
            end
            r_valid = 1'b0; r_last = 1'b0;
        end else begin
            for (int i = 0; i <= int'(v.len); i++) begin
                wdata_valid = 1'b1;
                wdata       = v.data0 + 32'(i);
                w_ready     = 1'b1;
                #1;
                chk("w_valid", 64'(w_valid), 64'd1);
                chk("wdata_ready", 64'(wdata_ready), 64'd1);
                chk("w_data", 64'(w_data), 64'(v.data0 + 32'(i)));
                chk("w_last", 64'(w_last), 64'(i == int'(v.len)));
                chk("w_id", 64'(w_id), 64'(v.id));
                @(negedge clk);
            end
            wdata_valid = 1'b0; w_ready = 1'b0;
            b_valid = 1'b1;
            b_id    = v.bad_id ? ~v.id : v.id;
            b_resp  = v.resp;
            #1;
            chk("b_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("b_ready", 64'(b_ready), 64'd1);
            chk("b_rsp_write", 64'(rsp_write), 64'd1);
            chk("b_rsp_last", 64'(rsp_last), 64'd1);
            chk("b_rsp_data", 64'(rsp_data), 64'd0);
            chk("b_rsp_err", 64'(rsp_err), 64'(v.exp_err));
            @(negedge clk);
            b_valid = 1'b0;
        end
        #1;
        chk("req_ready_after", 64'(req_ready), 64'd1);
        chk("rsp_valid_after", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        vec_t rv;
        //            wr    addr      len  id    resp  bid   blst stl data0         err
        vecs[0] = '{1'b0, 32'h08, 4'd0,  2'd1, 2'd0, 1'b0, 1'b0, 0, 32'h1,       1'b0};
        vecs[1] = '{1'b1, 32'h04, 4'd3,  2'd2, 2'd0, 1'b0, 1'b0, 0, 32'h0,       1'b0};
        vecs[2] = '{1'b0, 32'h10, 4'd1,  2'd3, 2'd0, 1'b0, 1'b0, 5, 32'hA0,      1'b0};
        vecs[3] = '{1'b0, 32'h20, 4'd0,  2'd0, 2'd0, 1'b1, 1'b0, 0, 32'h5,       1'b1};
        vecs[4] = '{1'b1, 32'h30, 4'd0,  2'd1, 2'd2, 1'b0, 1'b0, 0, 32'h77,      1'b1};
        vecs[5] = '{1'b0, 32'h40, 4'd15, 2'd2, 2'd0, 1'b0, 1'b0, 0, 32'h100,     1'b0};
        vecs[6] = '{1'b0, 32'h50, 4'd1,  2'd3, 2'd0, 1'b0, 1'b1, 0, 32'h200,     1'b1};
        vecs[7] = '{1'b0, 32'h60, 4'd0,  2'd0, 2'd2, 1'b0, 1'b0, 0, 32'h300,     1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("rst_aw_valid", 64'(aw_valid), 64'd0);
        chk("rst_w_valid", 64'(w_valid), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        chk("rst_b_ready", 64'(b_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ar_addr", 64'(ar_addr), 64'd0);
        chk("rst_ar_id", 64'(ar_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1 chk("rel_req_ready_0", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1 chk("rel_req_ready_1", 64'(req_ready), 64'd1);

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset in the middle of a read burst abandons it and clears tid.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70; req_len = 4'd1;
        @(negedge clk);
        req_valid = 1'b0; ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h55; r_id = 2'd1; r_last = 1'b0;
        #1 chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        nrst = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_r_ready", 64'(r_ready), 64'd0);
        chk("mid_rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        r_valid = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        rv = '{1'b0, 32'h80, 4'd0, 2'd1, 2'd0, 1'b0, 1'b0, 0, 32'h9, 1'b0};
        run_vec(rv);

`ifdef AXI_MASTER_TIMEOUT_EN
        begin
            int cyc;
            @(negedge clk);
            req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h90; req_len = 4'd0;
            @(negedge clk);
            req_valid = 1'b0; ar_ready = 1'b1;
            @(negedge clk);
            ar_ready = 1'b0;
            cyc = 0;
            #1;
            while (!rsp_valid && cyc < 1100) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            chk("tout_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("tout_not_early", 64'(cyc >= 1024), 64'd1);
            chk("tout_rsp_err", 64'(rsp_err), 64'd1);
            chk("tout_rsp_last", 64'(rsp_last), 64'd1);
            chk("tout_rsp_data", 64'(rsp_data), 64'h0000_0000_DEAD_BEEF);
            @(negedge clk);
            r_valid = 1'b1; r_data = 32'h1234; r_last = 1'b1;
            #1;
            chk("drain_r_ready", 64'(r_ready), 64'd1);
            chk("drain_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            r_valid = 1'b0; r_last = 1'b0;
            #1 chk("drain_idle", 64'(req_ready), 64'd1);
        end
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
